// File: rtl/defuzz_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : defuzz_div_seq
//  Description : Centroid defuzzifier. Computes g = round(s_wg / s_w * OUT_MAX)
//                exactly with a bit-serial restoring divider. Zero-weight and
//                saturating inputs take a one-cycle fast path.
//  Revision    : 1.0 - initial release
// ============================================================================
module defuzz_div_seq #(
    parameter int W        = 16,
    parameter int OUT_W    = 8,
    parameter int OUT_MAX  = 100,
    parameter int EPS      = 1,
    parameter int DFLT_OUT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s_w,
    input  logic [W-1:0]     s_wg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] g_out,
    output logic             zero_w,
    output logic             sat
);

    // Numerator 2*s_wg*OUT_MAX + s_w needs W + clog2(OUT_MAX) + 2 bits;
    // the partial remainder never exceeds twice the divisor (W+1 bits) plus one.
    localparam int               c_NW     = W + $clog2(OUT_MAX) + 2;
    localparam int               c_RW     = W + 2;
    localparam int               c_CW     = $clog2(OUT_W + 1);
    localparam logic [c_NW-1:0]  c_OMAX_N = c_NW'(OUT_MAX);
    localparam logic [OUT_W-1:0] c_OMAX   = OUT_W'(OUT_MAX);
    localparam logic [OUT_W-1:0] c_DFLT   = OUT_W'(DFLT_OUT);
    localparam logic [W-1:0]     c_EPS    = W'(EPS);
    localparam logic [c_CW-1:0]  c_LAST   = c_CW'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_zero_in;
    logic              w_sat_in;
    logic              w_fast;

    logic [W-1:0]      r_sw;
    logic [c_RW-1:0]   r_rem;
    logic [OUT_W-1:0]  r_qn;
    logic [c_CW-1:0]   r_cnt;
    logic [OUT_W-1:0]  r_g;
    logic              r_zero;
    logic              r_sat;

    logic [c_NW-1:0]   w_num;
    logic [c_RW-1:0]   w_dx;
    logic [c_RW-1:0]   w_trial;
    logic [c_RW-1:0]   w_diff;
    logic [c_RW-1:0]   w_rem_nxt;
    logic              w_ge;
    logic [OUT_W-1:0]  w_qn_nxt;
    logic [OUT_W-1:0]  w_q_clip;

    // Operand classification and one restoring-division step.
    // r_qn starts as the low numerator bits and is shifted out MSB first while
    // quotient bits shift in from the bottom, so it ends holding the quotient.
    always_comb begin
        w_zero_in = (s_w < c_EPS);
        w_sat_in  = (s_wg >= s_w);
        w_fast    = w_zero_in | w_sat_in;
        w_num     = ((c_NW'(s_wg) * c_OMAX_N) << 1) + c_NW'(s_w);
        w_dx      = {1'b0, r_sw, 1'b0};
        w_trial   = (r_rem << 1) | c_RW'(r_qn[OUT_W-1]);
        w_ge      = (w_trial >= w_dx);
        w_diff    = w_trial - w_dx;
        w_rem_nxt = w_ge ? w_diff : w_trial;
        w_qn_nxt  = (r_qn << 1) | OUT_W'(w_ge);
        w_q_clip  = (w_qn_nxt > c_OMAX) ? c_OMAX : w_qn_nxt;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs and next-state decode; a HOLD result retires in the
    // same cycle a new operand pair is accepted.
    always_comb begin
        out_valid   = (r_state == S_HOLD);
        in_ready    = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
        w_accept    = in_valid && in_ready;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? S_HOLD : S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_state_nxt = w_fast ? S_HOLD : S_DIV;
                end else if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, iterative division and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw   <= '0;
            r_rem  <= '0;
            r_qn   <= '0;
            r_cnt  <= '0;
            r_g    <= '0;
            r_zero <= 1'b0;
            r_sat  <= 1'b0;
        end else if (w_accept) begin
            r_sw  <= s_w;
            r_rem <= c_RW'(w_num >> OUT_W);
            r_qn  <= w_num[OUT_W-1:0];
            r_cnt <= '0;
            if (w_zero_in) begin
                r_g    <= c_DFLT;
                r_zero <= 1'b1;
                r_sat  <= 1'b0;
            end else if (w_sat_in) begin
                r_g    <= c_OMAX;
                r_zero <= 1'b0;
                r_sat  <= 1'b1;
            end
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_nxt;
            r_qn  <= w_qn_nxt;
            r_cnt <= r_cnt + c_CW'(1);
            if (r_cnt == c_LAST) begin
                r_g    <= w_q_clip;
                r_zero <= 1'b0;
                r_sat  <= 1'b0;
            end
        end
    end

    assign g_out  = r_g;
    assign zero_w = r_zero;
    assign sat    = r_sat;

endmodule
`default_nettype wire
